// File: rtl/pe_cmd_issuer.sv
// pe_cmd_issuer: sequences one PE through a MAC job.
// Flow: RESET, SET_CONV_MODE, optional LOAD_DATA, one TRIGGER per operand pair.
// It then waits for pe_busy to clear and returns mac_value on a ready/valid port.
module pe_cmd_issuer #(
   parameter int unsigned ACLEN          = 8,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned LEN_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst,
   input  logic                  job_valid,
   output logic                  job_ready,
   input  logic [LEN_WIDTH-1:0]  job_conv_len,
   input  logic                  job_preload_en,
   input  logic [DATA_WIDTH-1:0] job_preload_data,
   input  logic                  op_valid,
   output logic                  op_ready,
   input  logic [DATA_WIDTH-1:0] op_data,
   input  logic [DATA_WIDTH-1:0] op_weight,
   output logic                  pe_cmd_valid,
   output logic [ACLEN:0]        pe_cmd,
   output logic [DATA_WIDTH-1:0] param_1_out,
   output logic [DATA_WIDTH-1:0] param_2_out,
   output logic [DATA_WIDTH-1:0] preload_data_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [DATA_WIDTH-1:0] weight_out,
   input  logic                  pe_busy,
   input  logic [DATA_WIDTH-1:0] mac_value_in,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [DATA_WIDTH-1:0] res_data,
   output logic                  res_error,
   output logic                  idle
);

   localparam int unsigned CMD_W  = ACLEN + 1;
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [ACLEN:0] CMD_RESET     = CMD_W'(0);
   localparam logic [ACLEN:0] CMD_TRIGGER   = CMD_W'(1);
   localparam logic [ACLEN:0] CMD_LOAD_DATA = CMD_W'(5);
   localparam logic [ACLEN:0] CMD_SET_CONV  = CMD_W'(6);

   // The PE registers busy one cycle after TRIGGER, so the first WAIT cycles are blind.
   localparam logic [WAIT_W-1:0] WAIT_GUARD = WAIT_W'(2);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RST     = 3'd1;
   localparam logic [2:0] ST_MODE    = 3'd2;
   localparam logic [2:0] ST_PRELOAD = 3'd3;
   localparam logic [2:0] ST_STREAM  = 3'd4;
   localparam logic [2:0] ST_WAIT    = 3'd5;
   localparam logic [2:0] ST_RESULT  = 3'd6;

   logic [2:0]            state_q, state_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  pre_en_q, pre_en_d;
   logic [DATA_WIDTH-1:0] pre_data_q, pre_data_d;
   logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic                  job_ready_q, job_ready_d;
   logic                  op_ready_q, op_ready_d;
   logic                  pe_cmd_valid_q, pe_cmd_valid_d;
   logic [ACLEN:0]        pe_cmd_q, pe_cmd_d;
   logic [DATA_WIDTH-1:0] param_1_q, param_1_d;
   logic [DATA_WIDTH-1:0] preload_data_q, preload_data_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] weight_q, weight_d;
   logic                  res_valid_q, res_valid_d;
   logic [DATA_WIDTH-1:0] res_data_q, res_data_d;
   logic                  res_error_q, res_error_d;
   logic                  idle_q, idle_d;
   logic [LEN_WIDTH-1:0]  beat_next;

   // State and output registers; synchronous reset clears everything and parks in IDLE.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         len_q          <= '0;
         pre_en_q       <= 1'b0;
         pre_data_q     <= '0;
         beat_cnt_q     <= '0;
         wait_cnt_q     <= '0;
         job_ready_q    <= 1'b0;
         op_ready_q     <= 1'b0;
         pe_cmd_valid_q <= 1'b0;
         pe_cmd_q       <= '0;
         param_1_q      <= '0;
         preload_data_q <= '0;
         data_q         <= '0;
         weight_q       <= '0;
         res_valid_q    <= 1'b0;
         res_data_q     <= '0;
         res_error_q    <= 1'b0;
         idle_q         <= 1'b1;
      end else begin
         state_q        <= state_d;
         len_q          <= len_d;
         pre_en_q       <= pre_en_d;
         pre_data_q     <= pre_data_d;
         beat_cnt_q     <= beat_cnt_d;
         wait_cnt_q     <= wait_cnt_d;
         job_ready_q    <= job_ready_d;
         op_ready_q     <= op_ready_d;
         pe_cmd_valid_q <= pe_cmd_valid_d;
         pe_cmd_q       <= pe_cmd_d;
         param_1_q      <= param_1_d;
         preload_data_q <= preload_data_d;
         data_q         <= data_d;
         weight_q       <= weight_d;
         res_valid_q    <= res_valid_d;
         res_data_q     <= res_data_d;
         res_error_q    <= res_error_d;
         idle_q         <= idle_d;
      end
   end

   // Next-state and next-output logic; outputs are computed one cycle ahead of use.
   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      pre_en_d       = pre_en_q;
      pre_data_d     = pre_data_q;
      beat_cnt_d     = beat_cnt_q;
      wait_cnt_d     = wait_cnt_q;
      job_ready_d    = job_ready_q;
      op_ready_d     = op_ready_q;
      pe_cmd_valid_d = 1'b0;
      pe_cmd_d       = pe_cmd_q;
      param_1_d      = param_1_q;
      preload_data_d = preload_data_q;
      data_d         = data_q;
      weight_d       = weight_q;
      res_valid_d    = res_valid_q;
      res_data_d     = res_data_q;
      res_error_d    = res_error_q;
      idle_d         = idle_q;
      beat_next      = beat_cnt_q + LEN_WIDTH'(1);

      case (state_q)
         ST_IDLE: begin
            job_ready_d = 1'b1;
            idle_d      = 1'b1;
            if (job_valid && job_ready_q) begin
               len_d          = job_conv_len;
               pre_en_d       = job_preload_en;
               pre_data_d     = job_preload_data;
               job_ready_d    = 1'b0;
               idle_d         = 1'b0;
               pe_cmd_valid_d = 1'b1;
               pe_cmd_d       = CMD_RESET;
               state_d        = ST_RST;
            end
         end
         ST_RST: begin
            pe_cmd_valid_d = 1'b1;
            pe_cmd_d       = CMD_SET_CONV;
            param_1_d      = DATA_WIDTH'(len_q);
            beat_cnt_d     = '0;
            state_d        = ST_MODE;
         end
         ST_MODE: begin
            if (len_q == '0) begin
               res_valid_d = 1'b1;
               res_data_d  = '0;
               res_error_d = 1'b0;
               state_d     = ST_RESULT;
            end else if (pre_en_q) begin
               pe_cmd_valid_d = 1'b1;
               pe_cmd_d       = CMD_LOAD_DATA;
               preload_data_d = pre_data_q;
               state_d        = ST_PRELOAD;
            end else begin
               op_ready_d = 1'b1;
               state_d    = ST_STREAM;
            end
         end
         ST_PRELOAD: begin
            op_ready_d = 1'b1;
            state_d    = ST_STREAM;
         end
         ST_STREAM: begin
            if (op_valid && op_ready_q) begin
               pe_cmd_valid_d = 1'b1;
               pe_cmd_d       = CMD_TRIGGER;
               data_d         = op_data;
               weight_d       = op_weight;
               beat_cnt_d     = beat_next;
               if (beat_next == len_q) begin
                  op_ready_d = 1'b0;
               end
            end else if (!op_ready_q) begin
               // Last TRIGGER is on the wire this cycle; start the wait window next.
               wait_cnt_d = '0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            if ((wait_cnt_q >= WAIT_GUARD) && !pe_busy) begin
               res_valid_d = 1'b1;
               res_data_d  = mac_value_in;
               res_error_d = 1'b0;
               state_d     = ST_RESULT;
            end else if (wait_cnt_q == WAIT_LAST) begin
               res_valid_d = 1'b1;
               res_data_d  = mac_value_in;
               res_error_d = 1'b1;
               state_d     = ST_RESULT;
            end
         end
         ST_RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               job_ready_d = 1'b1;
               idle_d      = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign job_ready        = job_ready_q;
   assign op_ready         = op_ready_q;
   assign pe_cmd_valid     = pe_cmd_valid_q;
   assign pe_cmd           = pe_cmd_q;
   assign param_1_out      = param_1_q;
   assign param_2_out      = '0;
   assign preload_data_out = preload_data_q;
   assign data_out         = data_q;
   assign weight_out       = weight_q;
   assign res_valid        = res_valid_q;
   assign res_data         = res_data_q;
   assign res_error        = res_error_q;
   assign idle             = idle_q;

endmodule

// File: tb/tb_pe_cmd_issuer.sv
// Directed bench for pe_cmd_issuer: command order/timing, streaming, wait, result, reset.
module tb_pe_cmd_issuer;

   localparam logic [8:0] C_RESET = 9'd0;
   localparam logic [8:0] C_TRIG  = 9'd1;
   localparam logic [8:0] C_LOAD  = 9'd5;
   localparam logic [8:0] C_MODE  = 9'd6;

   logic        clk_i, rst;
   logic        job_valid, job_ready;
   logic [15:0] job_conv_len;
   logic        job_preload_en;
   logic [31:0] job_preload_data;
   logic        op_valid, op_ready;
   logic [31:0] op_data, op_weight;
   logic        pe_cmd_valid;
   logic [8:0]  pe_cmd;
   logic [31:0] param_1_out, param_2_out, preload_data_out, data_out, weight_out;
   logic        pe_busy;
   logic [31:0] mac_value_in;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic        res_error, idle;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   pe_cmd_issuer #(
      .ACLEN(8), .DATA_WIDTH(32), .LEN_WIDTH(16), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk_i), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_conv_len(job_conv_len), .job_preload_en(job_preload_en),
      .job_preload_data(job_preload_data),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_data(op_data), .op_weight(op_weight),
      .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd),
      .param_1_out(param_1_out), .param_2_out(param_2_out),
      .preload_data_out(preload_data_out),
      .data_out(data_out), .weight_out(weight_out),
      .pe_busy(pe_busy), .mac_value_in(mac_value_in),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_error(res_error), .idle(idle)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Cycle index: value seen #1 after a posedge names the cycle that edge started.
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Runs one job end to end with a small PE model, then checks commands and result.
   task automatic run_job(input string name, input int len, input bit pre_en,
                          input logic [31:0] pre_data, input bit bubble, input bit stuck,
                          input logic [31:0] mac, input int hold);
      int t, n, acc, last_trig, first_rdy, r, k, nexp;
      logic [8:0]  cq[$];
      int          ccq[$];
      int          aq[$];
      logic [31:0] dq[$], wq[$], pq[$], lq[$];
      logic [31:0] rd;

      mac_value_in     = mac;
      job_conv_len     = 16'(len);
      job_preload_en   = pre_en;
      job_preload_data = pre_data;
      job_valid        = 1'b1;
      n = 0;
      while (!job_ready && n < 20) begin
         step();
         n++;
      end
      check_eq({name, "/job_ready"}, 64'(job_ready), 64'd1);
      t = cyc;
      step();
      job_valid = 1'b0;

      last_trig = -100;
      first_rdy = -1;
      acc = 0;
      n = 0;
      while (!res_valid && n < 200) begin
         pe_busy = stuck || (cyc >= last_trig + 1 && cyc <= last_trig + 8);
         if (pe_cmd_valid) begin
            cq.push_back(pe_cmd);
            ccq.push_back(cyc);
            dq.push_back(data_out);
            wq.push_back(weight_out);
            pq.push_back(param_1_out);
            lq.push_back(preload_data_out);
            if (pe_cmd == C_TRIG) last_trig = cyc;
         end
         if (op_ready && first_rdy < 0) first_rdy = cyc;
         op_valid  = !bubble || (cyc % 2 == 0);
         op_data   = 32'(acc + 1);
         op_weight = 32'h3F80_0000;
         if (op_valid && op_ready) begin
            aq.push_back(cyc);
            acc++;
         end
         step();
         n++;
      end
      op_valid = 1'b0;
      pe_busy  = 1'b0;
      r = cyc;

      nexp = 2 + ((pre_en && len != 0) ? 1 : 0) + len;
      check_eq({name, "/ncmd"}, 64'(cq.size()), 64'(nexp));
      check_eq({name, "/naccept"}, 64'(aq.size()), 64'(len));
      if (cq.size() >= 2) begin
         check_eq({name, "/cmd0"}, 64'(cq[0]), 64'(C_RESET));
         check_eq({name, "/cmd0_cyc"}, 64'(ccq[0]), 64'(t + 1));
         check_eq({name, "/cmd1"}, 64'(cq[1]), 64'(C_MODE));
         check_eq({name, "/cmd1_cyc"}, 64'(ccq[1]), 64'(t + 2));
         check_eq({name, "/param1"}, 64'(pq[1]), 64'(len));
      end
      k = 2;
      if (pre_en && len != 0 && cq.size() >= 3) begin
         check_eq({name, "/load"}, 64'(cq[2]), 64'(C_LOAD));
         check_eq({name, "/load_cyc"}, 64'(ccq[2]), 64'(t + 3));
         check_eq({name, "/load_data"}, 64'(lq[2]), 64'(pre_data));
         k = 3;
      end
      for (int i = 0; i < len && k + i < cq.size() && i < aq.size(); i++) begin
         check_eq({name, "/trig"}, 64'(cq[k+i]), 64'(C_TRIG));
         check_eq({name, "/trig_data"}, 64'(dq[k+i]), 64'(i + 1));
         check_eq({name, "/trig_wgt"}, 64'(wq[k+i]), 64'h3F80_0000);
         check_eq({name, "/trig_cyc"}, 64'(ccq[k+i]), 64'(aq[i] + 1));
      end
      if (len != 0) begin
         check_eq({name, "/first_op_ready"}, 64'(first_rdy), 64'(t + 3 + (pre_en ? 1 : 0)));
      end else begin
         check_eq({name, "/op_ready_never"}, 64'(first_rdy), 64'(-1));
      end

      check_eq({name, "/res_valid"}, 64'(res_valid), 64'd1);
      check_eq({name, "/res_data"}, 64'(res_data), (len != 0) ? 64'(mac) : 64'd0);
      check_eq({name, "/res_error"}, 64'(res_error), 64'(stuck));
      if (len == 0)
         check_eq({name, "/res_cyc"}, 64'(r), 64'(t + 3));
      else if (stuck)
         check_eq({name, "/res_cyc"}, 64'(r), 64'(last_trig + 17));
      else
         check_eq({name, "/res_cyc"}, 64'(r), 64'(last_trig + 10));

      rd = res_data;
      for (int h = 0; h < hold; h++) begin
         step();
         check_eq({name, "/hold_valid"}, 64'(res_valid), 64'd1);
         check_eq({name, "/hold_data"}, 64'(res_data), 64'(rd));
         check_eq({name, "/hold_job_ready"}, 64'(job_ready), 64'd0);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check_eq({name, "/res_drop"}, 64'(res_valid), 64'd0);
      check_eq({name, "/idle_after"}, 64'(idle), 64'd1);
      check_eq({name, "/job_ready_after"}, 64'(job_ready), 64'd1);
   endtask

   initial begin
      int acc, n;
      rst = 1'b1;
      job_valid = 1'b0; job_conv_len = '0; job_preload_en = 1'b0; job_preload_data = '0;
      op_valid = 1'b0; op_data = '0; op_weight = '0;
      pe_busy = 1'b0; mac_value_in = '0; res_ready = 1'b0;
      repeat (3) step();
      check_eq("rst/job_ready", 64'(job_ready), 64'd0);
      check_eq("rst/idle", 64'(idle), 64'd1);
      check_eq("rst/op_ready", 64'(op_ready), 64'd0);
      check_eq("rst/pe_cmd_valid", 64'(pe_cmd_valid), 64'd0);
      check_eq("rst/res_valid", 64'(res_valid), 64'd0);
      rst = 1'b0;
      step();
      check_eq("rst/job_ready_rise", 64'(job_ready), 64'd1);

      run_job("basic",   4, 1'b0, 32'h0,         1'b0, 1'b0, 32'h4120_0000, 0);
      run_job("bubble",  4, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4120_0000, 0);
      run_job("preload", 2, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'h4000_0000, 0);
      run_job("zero",    0, 1'b1, 32'h3F80_0000, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
      run_job("timeout", 3, 1'b0, 32'h0,         1'b0, 1'b1, 32'h1234_5678, 0);
      run_job("hold",    1, 1'b0, 32'h0,         1'b0, 1'b0, 32'hCAFE_F00D, 5);

      // Reset in the middle of streaming.
      job_conv_len = 16'd4; job_preload_en = 1'b0; job_valid = 1'b1;
      step();
      job_valid = 1'b0;
      op_valid = 1'b1; op_data = 32'h55; op_weight = 32'h66;
      acc = 0; n = 0;
      while (acc < 2 && n < 20) begin
         if (op_valid && op_ready) acc++;
         step();
         n++;
      end
      check_eq("mid/in_stream", 64'(op_ready), 64'd1);
      rst = 1'b1;
      op_valid = 1'b0;
      step();
      check_eq("mid/op_ready", 64'(op_ready), 64'd0);
      check_eq("mid/pe_cmd_valid", 64'(pe_cmd_valid), 64'd0);
      check_eq("mid/pe_cmd", 64'(pe_cmd), 64'd0);
      check_eq("mid/data_out", 64'(data_out), 64'd0);
      check_eq("mid/weight_out", 64'(weight_out), 64'd0);
      check_eq("mid/param_1", 64'(param_1_out), 64'd0);
      check_eq("mid/param_2", 64'(param_2_out), 64'd0);
      check_eq("mid/job_ready", 64'(job_ready), 64'd0);
      check_eq("mid/res_valid", 64'(res_valid), 64'd0);
      check_eq("mid/idle", 64'(idle), 64'd1);
      rst = 1'b0;
      step();

      run_job("after_rst", 4, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4120_0000, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pe_cmd_issuer.md
# pe_cmd_issuer

Command initiator that drives the pe_cmd interface of one Processing Element (PE) for a single convolution/MAC job. It accepts a job descriptor, then issues RESET, SET_CONV_MODE, an optional LOAD_DATA, and one TRIGGER per operand pair taken from an operand stream. It then waits for the PE busy flag to clear and returns the PE mac_value on a ready/valid result port. It sits between the GeMM tile controller and a PE, replacing hand-sequenced command writes.

## Interface
- ACLEN, 8, pe_cmd is ACLEN+1 bits wide
- DATA_WIDTH, 32, operand/param/result width
- LEN_WIDTH, 16, width of job_conv_len and beat counter
- TIMEOUT_CYCLES, 1024, max WAIT cycles with pe_busy high before error
- clk_i  in  1  clock
- rst  in  1  reset, synchronous, active-high
- job_valid / job_ready  in/out  1  job descriptor handshake
- job_conv_len  in  LEN_WIDTH  number of operand beats
- job_preload_en  in  1  issue LOAD_DATA before streaming
- job_preload_data  in  DATA_WIDTH  value for preload_data_out
- op_valid / op_ready  in/out  1  operand stream handshake
- op_data, op_weight  in  DATA_WIDTH  operand pair
- pe_cmd_valid  out  1  command strobe to PE
- pe_cmd  out  ACLEN+1  RESET=0, TRIGGER=1, LOAD_DATA=5, SET_CONV_MODE=6
- param_1_out, param_2_out, preload_data_out  out  DATA_WIDTH  command params
- data_out, weight_out  out  DATA_WIDTH  PE data_in/weight_in
- pe_busy  in  1  PE busy flag
- mac_value_in  in  DATA_WIDTH  PE mac_value
- res_valid / res_ready  out/in  1  result handshake
- res_data  out  DATA_WIDTH  returned accumulator value
- res_error  out  1  timeout flag, qualified by res_valid
- idle  out  1  high in IDLE

## Operation
- All PE-side outputs are registered. On reset every output is 0, the FSM is in IDLE, and idle=1.
- job_ready=1 only in IDLE. Descriptor fields are latched on accept.
- FSM states: IDLE -> RST -> MODE -> [PRELOAD] -> STREAM -> WAIT -> RESULT -> IDLE.
- RST: one-cycle pe_cmd=RESET.
- MODE: one-cycle pe_cmd=SET_CONV_MODE with param_1_out = job_conv_len zero-extended to DATA_WIDTH.
- PRELOAD is entered only if job_preload_en=1 and conv_len!=0. It issues one-cycle pe_cmd=LOAD_DATA with preload_data_out=job_preload_data.
- STREAM: op_ready=1. Each accepted pair produces one pe_cmd=TRIGGER on the next cycle, with data_out/weight_out = the pair.
  - Cycles with no handshake drive pe_cmd_valid=0. The PE has no backpressure.
  - The beat counter increments per accept. After accept number conv_len, op_ready drops in the same cycle it is registered and the FSM moves to WAIT.
- param_2_out is always 0.
- When pe_cmd_valid=0, pe_cmd and the data fields hold their last values. Verification checks them only when pe_cmd_valid=1.
- conv_len=0: RST and MODE are still issued. PRELOAD and STREAM are skipped. WAIT is skipped. RESULT returns res_data=0, res_error=0, and mac_value_in is not sampled.
- WAIT:
  - Ignores pe_busy for the first 2 cycles (guard for the registered busy set).
  - After that, the first cycle with pe_busy=0 captures mac_value_in into res_data and enters RESULT.
  - If the wait counter reaches TIMEOUT_CYCLES first, it captures mac_value_in and sets res_error=1.
- RESULT: res_valid held with stable res_data/res_error until res_ready. The FSM returns to IDLE on the handshake.
- rst in any state returns to IDLE with all outputs 0 next cycle. No RESET command is emitted, since the PE shares rst.

## Timing
- Job accepted at cycle T: RESET at T+1, SET_CONV_MODE at T+2, LOAD_DATA at T+3 if enabled.
- op_ready first rises at T+3 (T+4 with preload).
- Operand accepted at S: TRIGGER visible at S+1. Sustained throughput is 1 beat/cycle.
- Last TRIGGER at L: WAIT occupies L+1..; pe_busy is first sampled at L+3.
- pe_busy=0 sampled at W: res_valid=1 at W+1.
- Timeout: res_valid at the cycle after the wait counter reaches TIMEOUT_CYCLES, counted from WAIT entry.
- New job_ready earliest the cycle after the res handshake. Back-to-back jobs have at least a 1-cycle IDLE gap.
- Beat counter and wait counter do not wrap. conv_len max is 2^LEN_WIDTH-1.

## Test plan
- Basic job: conv_len=4, preload_en=0, ops (1..4, 0x3F800000) always valid; model pe_busy high L+1..L+8, mac_value_in=0x41200000.
  - Required: RESET@T+1; SET_CONV_MODE param_1=4 @T+2; 4 consecutive TRIGGERs carrying the ops in order; res_data=0x41200000, res_error=0.
- Bubbles: same job with op_valid low every other cycle.
  - Required: exactly 4 TRIGGERs, each 1 cycle after its accept; pe_cmd_valid=0 on gap cycles; no extra beat accepted.
- Preload: preload_en=1, preload_data=0x3F800000, conv_len=2.
  - Required: LOAD_DATA with preload_data_out=0x3F800000 at T+3, between SET_CONV_MODE and the first TRIGGER.
- Zero length: conv_len=0, preload_en=1.
  - Required: RESET, SET_CONV_MODE param_1=0, no LOAD_DATA, no TRIGGER, op_ready never high; res_valid with res_data=0.
- Timeout: pe_busy stuck at 1, TIMEOUT_CYCLES=16.
  - Required: res_valid with res_error=1, res_data=mac_value_in.
- Hold and reset:
  - res_ready low 5 cycles: res_valid/res_data stable, job_ready=0.
  - rst asserted mid-STREAM: next cycle all outputs 0, idle=1, op_ready=0, and the next job runs normally.
